nor_gate: RTL and testbench

NOR_GATE -- requirements
Module: nor_gate

---
 rtl/nor_gate.sv | 38 +++
 tb/tb_nor_gate.sv | 130 +++++++++++++
 2 files changed

// File: rtl/nor_gate.sv
// Bitwise NOR with a combinational output and a one-cycle registered copy
// (result, reduction NOR of the operands, and a valid pulse).
module nor_gate #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic             in_valid,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] out_q,
    output logic             out_valid,
    output logic             red_q
);

    // Single NOR term feeds both paths so out and out_q can never disagree.
    logic [WIDTH-1:0] nor_v;

    assign nor_v = ~(in1 | in2);
    assign out   = nor_v;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_q     <= '0;
            red_q     <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                out_q <= nor_v;
                // ~|(in1|in2) is the AND-reduction of the shared NOR term
                red_q <= &nor_v;
            end
        end
    end

endmodule

// File: tb/tb_nor_gate.sv
// Directed bench for nor_gate: a WIDTH=1 instance for the truth table and a
// WIDTH=8 instance for the registered path, reset priority and streaming.
module tb_nor_gate;

    logic       clk = 1'b0;
    logic       rst;
    int         checks = 0;
    int         errors = 0;

    logic       a1, b1, v1;
    logic       o1, oq1, ov1, rq1;

    logic [7:0] a8, b8, o8, oq8;
    logic       v8, ov8, rq8;

    always #5 clk = ~clk;

    nor_gate #(.WIDTH(1)) dut1 (
        .clk(clk), .rst(rst), .in1(a1), .in2(b1), .in_valid(v1),
        .out(o1), .out_q(oq1), .out_valid(ov1), .red_q(rq1)
    );

    nor_gate #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .in1(a8), .in2(b8), .in_valid(v8),
        .out(o8), .out_q(oq8), .out_valid(ov8), .red_q(rq8)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        a1 = 1'b0; b1 = 1'b0; v1 = 1'b1;
        a8 = 8'hA5; b8 = 8'h0F; v8 = 1'b1;

        // Reset wins over in_valid; out keeps tracking inputs.
        tick();
        chk("rst_outq", oq8, 8'h00);
        chk("rst_red", {7'd0, rq8}, 8'h00);
        chk("rst_vld", {7'd0, ov8}, 8'h00);
        chk("rst_out_track", o8, 8'h50);
        chk("rst_outq_w1", {7'd0, oq1}, 8'h00);
        chk("rst_red_w1", {7'd0, rq1}, 8'h00);
        a8 = 8'h00; b8 = 8'h00; #1;
        chk("rst_out_track2", o8, 8'hFF);
        tick();
        chk("rst_hold_outq", oq8, 8'h00);
        chk("rst_hold_vld", {7'd0, ov8}, 8'h00);

        // WIDTH=1 truth table at 10-unit steps.
        v1 = 1'b0; v8 = 1'b0;
        a1 = 1'b0; b1 = 1'b0; #1; chk("tt_00", {7'd0, o1}, 8'h01); #9;
        a1 = 1'b0; b1 = 1'b1; #1; chk("tt_01", {7'd0, o1}, 8'h00); #9;
        a1 = 1'b1; b1 = 1'b0; #1; chk("tt_10", {7'd0, o1}, 8'h00); #9;
        a1 = 1'b1; b1 = 1'b1; #1; chk("tt_11", {7'd0, o1}, 8'h00); #9;

        // Release reset; first capture on first valid edge.
        @(negedge clk);
        rst = 1'b0;
        tick();
        chk("idle_vld", {7'd0, ov8}, 8'h00);

        a1 = 1'b0; b1 = 1'b0; v1 = 1'b1;
        a8 = 8'hA5; b8 = 8'h0F; v8 = 1'b1; #1;
        chk("a5_0f_out", o8, 8'h50);
        tick();
        chk("a5_0f_outq", oq8, 8'h50);
        chk("a5_0f_red", {7'd0, rq8}, 8'h00);
        chk("a5_0f_vld", {7'd0, ov8}, 8'h01);
        chk("w1_outq", {7'd0, oq1}, 8'h01);
        chk("w1_red", {7'd0, rq1}, 8'h01);
        v1 = 1'b0; v8 = 1'b0;
        a8 = 8'hFF; b8 = 8'hFF;
        tick();
        chk("a5_0f_vld_drop", {7'd0, ov8}, 8'h00);
        chk("hold_outq", oq8, 8'h50);
        chk("hold_red", {7'd0, rq8}, 8'h00);

        // All-zero operands.
        a8 = 8'h00; b8 = 8'h00; v8 = 1'b1; #1;
        chk("zero_out", o8, 8'hFF);
        tick();
        chk("zero_outq", oq8, 8'hFF);
        chk("zero_red", {7'd0, rq8}, 8'h01);
        chk("zero_vld", {7'd0, ov8}, 8'h01);

        // Three back-to-back beats.
        a8 = 8'h01; b8 = 8'h02; v8 = 1'b1;
        tick();
        chk("beat1_outq", oq8, 8'hFC);
        chk("beat1_vld", {7'd0, ov8}, 8'h01);
        chk("beat1_red", {7'd0, rq8}, 8'h00);
        a8 = 8'hF0; b8 = 8'h0F;
        tick();
        chk("beat2_outq", oq8, 8'h00);
        chk("beat2_vld", {7'd0, ov8}, 8'h01);
        a8 = 8'h00; b8 = 8'h80;
        tick();
        chk("beat3_outq", oq8, 8'h7F);
        chk("beat3_vld", {7'd0, ov8}, 8'h01);
        chk("beat3_red", {7'd0, rq8}, 8'h00);
        v8 = 1'b0;
        tick();
        chk("beats_done_vld", {7'd0, ov8}, 8'h00);
        chk("beats_hold_outq", oq8, 8'h7F);

        // Reset mid-run with a valid beat on the same edge.
        rst = 1'b1; a8 = 8'h00; b8 = 8'h00; v8 = 1'b1;
        tick();
        chk("rst2_outq", oq8, 8'h00);
        chk("rst2_red", {7'd0, rq8}, 8'h00);
        chk("rst2_vld", {7'd0, ov8}, 8'h00);
        chk("rst2_out_track", o8, 8'hFF);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
